// File: rtl/gray_conv_arbiter_if.sv
// Bus between two Gray-code requesters and the shared converter.
//
// Handshake: each requester raises reqN with grayN stable and holds both
// until it sees a one-cycle ackN; the operand is captured on the edge that
// raises ackN. Results come back as a one-cycle bin_valid pulse with
// bin_out/bin_id, which then hold until the next result.
interface gray_conv_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic [WIDTH-1:0] gray0;
   logic             ack0;
   logic             req1;
   logic [WIDTH-1:0] gray1;
   logic             ack1;
   logic [WIDTH-1:0] bin_out;
   logic             bin_valid;
   logic             bin_id;
   logic             busy;
   logic [1:0]       state_dbg;

   // requester / environment side
   modport master (
      output req0, gray0, req1, gray1,
      input  ack0, ack1, bin_out, bin_valid, bin_id, busy, state_dbg
   );

   // converter side
   modport slave (
      input  req0, gray0, req1, gray1,
      output ack0, ack1, bin_out, bin_valid, bin_id, busy, state_dbg
   );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Serial Gray-to-binary converter shared by two requesters under
// round-robin arbitration. One bit is produced per clock, MSB first;
// the finished result is published in a single DONE cycle.
module gray_conv_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gray_conv_arbiter_if.slave   bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_sh;       // remaining Gray bits, MSB at the top
   logic [WIDTH-1:0] r_acc;      // binary bits produced so far, newest in bit 0
   logic [CW-1:0]    r_cnt;      // index of the bit being produced this cycle
   logic             r_id;       // owner of the conversion in flight
   logic             r_last;     // most recently granted requester
   logic             r_ack0;
   logic             r_ack1;
   logic [WIDTH-1:0] r_bin;
   logic             r_bin_id;
   logic             r_valid;

   logic             w_grant;
   logic             w_gid;
   logic             w_shift;
   logic             w_done;
   logic [WIDTH-1:0] w_gray_sel;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state, arbitration and datapath controls.
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_gid   = 1'b0;
      w_shift = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               w_grant = 1'b1;
               // On a tie the requester that did not win last time goes.
               w_gid   = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
               w_next  = S_CONV;
            end
         end
         S_CONV: begin
            w_shift = 1'b1;
            if (r_cnt == '0) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            // No grant here: a waiting requester is picked up in IDLE.
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign w_gray_sel = w_gid ? bus.gray1 : bus.gray0;

   // Handshake pulses: one cycle each, registered from the decision above.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_ack0  <= w_grant & ~w_gid;
         r_ack1  <= w_grant &  w_gid;
         r_valid <= w_done;
      end
   end

   // Grant bookkeeping: owner of the conversion and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id   <= 1'b0;
         r_last <= 1'b1;
      end else if (w_grant) begin
         r_id   <= w_gid;
         r_last <= w_gid;
      end
   end

   // Serial conversion: each new binary bit is the previous binary bit
   // XOR the next Gray bit; the accumulator starts at zero so the MSB
   // comes out equal to the Gray MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh  <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_grant) begin
         r_sh  <= w_gray_sel;
         r_acc <= '0;
         r_cnt <= LAST_IDX;
      end else if (w_shift) begin
         r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
         r_acc <= {r_acc[WIDTH-2:0], r_acc[0] ^ r_sh[WIDTH-1]};
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   // Result register: only the completed word is ever made visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin    <= '0;
         r_bin_id <= 1'b0;
      end else if (w_done) begin
         r_bin    <= r_acc;
         r_bin_id <= r_id;
      end
   end

   assign bus.ack0      = r_ack0;
   assign bus.ack1      = r_ack1;
   assign bus.bin_out   = r_bin;
   assign bus.bin_valid = r_valid;
   assign bus.bin_id    = r_bin_id;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed cases from the test plan followed by
// randomized requests, checked against a reference model that converts Gray
// to binary by XOR-folding shifted copies and tracks round-robin order.
module tb_gray_conv_arbiter;

   localparam int W = 4;

   logic clk;
   logic rst_n;

   int   n_cmp;
   int   n_err;
   logic m_last;              // model: last requester served
   logic [W:0] exp_q[$];      // {id, bin} expected, in completion order
   logic [W:0] mon_e;

   gray_conv_arbiter_if #(.WIDTH(W)) bus();

   gray_conv_arbiter #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Binary value of a Gray code: bit i is the XOR of all Gray bits >= i.
   function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = '0;
      for (int s = 0; s < W; s++) b = b ^ (g >> s);
      return b;
   endfunction

   // scoreboard: every result pulse must match the next expected entry
   always @(negedge clk) begin
      if (rst_n && bus.bin_valid) begin
         check_eq("valid_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_eq("bin_out", 32'(bus.bin_out), 32'(mon_e[W-1:0]));
            check_eq("bin_id", 32'(bus.bin_id), 32'(mon_e[W]));
         end
      end
   end

   function automatic logic [31:0] out_vec();
      return 32'({bus.ack0, bus.ack1, bus.bin_valid, bus.busy, bus.bin_id, bus.bin_out});
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      #1;
      check_eq("reset_outputs", out_vec(), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1;
      exp_q.delete();
   endtask

   // Drive one round: requester 0 and/or 1. With d1 > 0, req1 is raised d1
   // cycles after req0 (mid-conversion) instead of together with it.
   task automatic serve(input logic r0, input logic r1, input logic [W-1:0] g0,
                        input logic [W-1:0] g1, input int d1);
      int   cnt;
      int   n_req;
      int   n_ack;
      int   nv;
      int   a_cnt[2];
      int   v_cnt[2];
      logic first_id;
      logic exp_first;
      logic [W-1:0] last_bin;
      n_req = int'(r0) + int'(r1);
      n_ack = 0;
      nv = 0;
      cnt = 0;
      first_id = 1'b0;
      a_cnt[0] = -1; a_cnt[1] = -1;
      v_cnt[0] = -1; v_cnt[1] = -1;
      if (r0 && r1 && d1 == 0) exp_first = ~m_last;
      else                     exp_first = r0 ? 1'b0 : 1'b1;
      exp_q.push_back({exp_first, ref_bin(exp_first ? g1 : g0)});
      last_bin = ref_bin(exp_first ? g1 : g0);
      m_last = exp_first;
      if (r0 && r1) begin
         exp_q.push_back({~exp_first, ref_bin(exp_first ? g0 : g1)});
         last_bin = ref_bin(exp_first ? g0 : g1);
         m_last = ~exp_first;
      end
      bus.gray0 = g0;
      bus.gray1 = g1;
      bus.req0  = r0;
      bus.req1  = r1 && (d1 == 0);
      while ((n_ack < n_req || nv < n_req) && cnt < 3 * W + 20) begin
         @(negedge clk);
         cnt++;
         if (r1 && d1 > 0 && cnt == d1) bus.req1 = 1'b1;
         check_eq("ack_overlap", 32'(bus.ack0 & bus.ack1), 0);
         if (bus.ack0 || bus.ack1) begin
            if (n_ack == 0) first_id = bus.ack1;
            if (n_ack < 2) a_cnt[n_ack] = cnt;
            n_ack++;
            if (bus.ack0) bus.req0 = 1'b0;
            if (bus.ack1) bus.req1 = 1'b0;
         end
         if (bus.bin_valid) begin
            if (nv < 2) v_cnt[nv] = cnt;
            nv++;
         end
      end
      check_eq("round_complete", 32'(n_ack == n_req && nv == n_req), 1);
      check_eq("first_grant_id", 32'(first_id), 32'(exp_first));
      check_eq("ack_latency", 32'(a_cnt[0]), 1);
      check_eq("valid_latency", 32'(v_cnt[0]), W + 2);
      if (n_req == 2) begin
         check_eq("ack2_latency", 32'(a_cnt[1]), W + 3);
         check_eq("valid2_latency", 32'(v_cnt[1]), 2 * W + 4);
      end
      @(negedge clk);
      check_eq("bin_hold", 32'(bus.bin_out), 32'(last_bin));
      check_eq("idle_not_busy", 32'(bus.busy), 0);
   endtask

   // Abort a conversion by reset two cycles after its ack.
   task automatic reset_mid_conv(input logic [W-1:0] g0);
      int cnt;
      cnt = 0;
      bus.gray0 = g0;
      bus.req0 = 1'b1;
      while (!bus.ack0 && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      check_eq("abort_ack_latency", 32'(cnt), 1);
      bus.req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("abort_busy_before", 32'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_outputs", out_vec(), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         check_eq("abort_quiet", out_vec(), 0);
      end
   endtask

   initial begin
      logic [W-1:0] corners[4];
      logic [W-1:0] rg0;
      logic [W-1:0] rg1;
      int           mode;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b1;
      m_last = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.gray0 = '0;
      bus.gray1 = '0;

      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle_quiet", out_vec(), 0);
      end

      serve(1'b1, 1'b0, 4'b1011, 4'b0000, 0);

      corners[0] = 4'b0000;
      corners[1] = 4'b1111;
      corners[2] = 4'b1000;
      corners[3] = 4'b0001;
      for (int i = 0; i < 4; i++) serve(1'b0, 1'b1, 4'b0000, corners[i], 0);

      do_reset();
      serve(1'b1, 1'b1, 4'b0110, 4'b0100, 0);
      serve(1'b1, 1'b1, 4'b0110, 4'b0100, 0);

      serve(1'b1, 1'b1, 4'b1100, 4'b0011, 3);

      reset_mid_conv(4'b1010);
      serve(1'b1, 1'b0, 4'b0111, 4'b0000, 0);

      for (int i = 0; i < 40; i++) begin
         rg0 = W'($urandom_range(0, (1 << W) - 1));
         rg1 = W'($urandom_range(0, (1 << W) - 1));
         mode = $urandom_range(0, 3);
         case (mode)
            0: serve(1'b1, 1'b0, rg0, rg1, 0);
            1: serve(1'b0, 1'b1, rg0, rg1, 0);
            2: serve(1'b1, 1'b1, rg0, rg1, 0);
            default: serve(1'b1, 1'b1, rg0, rg1, $urandom_range(1, W));
         endcase
      end

      repeat (3) @(negedge clk);
      check_eq("queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
